// File: rtl/sum_of_squares.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sum_of_squares                                                |
// | Brief    : Streaming energy accumulator. Squares signed samples, sums    |
// |            the squares over a last-delimited vector and emits one 32-bit |
// |            unsigned sum per vector, fixed three-cycle latency.           |
// | Options  : SOS_SATURATE_EN - clamp the sum to 32'hFFFF_FFFF on overflow  |
// |            (default build wraps modulo 2^32).                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sum_of_squares #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       sample_last,
  output logic [31:0]                data_out,
  output logic                       data_valid,
  output logic                       overflow,
  output logic [CNT_W-1:0]           vec_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Stage 1: input register
  logic signed [SAMPLE_W-1:0] s1_sample_q;
  logic                       s1_valid_q;
  logic                       s1_last_q;

  // Stage 2: square register
  logic [31:0]                s2_sq_q;
  logic [31:0]                s2_sq_d;
  logic                       s2_valid_q;
  logic                       s2_last_q;
  logic signed [2*SAMPLE_W-1:0] prod;

  // Stage 3: accumulator state and output register
  logic [31:0]                acc_q;
  logic [31:0]                acc_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic                       ovf_q;
  logic                       ovf_d;
  logic                       first_q;
  logic [32:0]                acc_sum;
  logic [31:0]                acc_base;

  logic [31:0]                data_out_q;
  logic                       data_valid_q;
  logic                       overflow_q;
  logic [CNT_W-1:0]           vec_len_q;

  // Capture the incoming sample; reset drops a coincident sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_sample_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
    end else begin
      s1_sample_q <= sample_in;
      s1_valid_q  <= sample_valid;
      s1_last_q   <= sample_valid & sample_last;
    end
  end

  // Square the sample; the result is non-negative and at most 2^(2*SAMPLE_W-2),
  // so widening the signed product to 32 bits never changes its value.
  always_comb begin
    prod    = s1_sample_q * s1_sample_q;
    s2_sq_d = 32'(unsigned'(prod));
  end

  // Register the square together with its valid/last tags.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_sq_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_sq_q    <= s2_sq_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
    end
  end

  // Next-state accumulation: a new vector starts from zero when first_q is set.
  always_comb begin
    acc_base = first_q ? 32'd0 : acc_q;
    acc_sum  = {1'b0, acc_base} + {1'b0, s2_sq_q};
    ovf_d    = (first_q ? 1'b0 : ovf_q) | acc_sum[32];
`ifdef SOS_SATURATE_EN
    acc_d    = ovf_d ? 32'hFFFF_FFFF : acc_sum[31:0];
`else
    acc_d    = acc_sum[31:0];
`endif
    if (first_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Update accumulator on valid elements only; bubbles leave state untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else if (s2_valid_q) begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      first_q <= s2_last_q;
    end
  end

  // Load the result register when the closing element reaches stage 3.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      vec_len_q    <= '0;
    end else begin
      data_valid_q <= s2_valid_q & s2_last_q;
      if (s2_valid_q && s2_last_q) begin
        data_out_q <= acc_d;
        overflow_q <= ovf_d;
        vec_len_q  <= cnt_d;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overflow   = overflow_q;
  assign vec_len    = vec_len_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_of_squares.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sum_of_squares                                             |
// | Brief    : Self-checking bench for sum_of_squares. A default instance    |
// |            and a CNT_W=2 instance share one input stream; expected       |
// |            results are queued at stimulus time and popped on each pulse. |
// | Options  : SOS_SATURATE_EN selects the clamping expectation.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sum_of_squares;

  logic               clock;
  logic               reset;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               sample_last;

  logic [31:0]        data_out;
  logic               data_valid;
  logic               overflow;
  logic [15:0]        vec_len;

  logic [31:0]        data_out2;
  logic               data_valid2;
  logic               overflow2;
  logic [1:0]         vec_len2;

  sum_of_squares #(.SAMPLE_W(16), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_last  (sample_last),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .vec_len      (vec_len)
  );

  sum_of_squares #(.SAMPLE_W(16), .CNT_W(2)) dut2 (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_last  (sample_last),
    .data_out     (data_out2),
    .data_valid   (data_valid2),
    .overflow     (overflow2),
    .vec_len      (vec_len2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic [15:0] len;
    logic [1:0]  len2;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  longint      m_sum    = 0;
  longint      m_n      = 0;
  bit          m_first  = 1'b1;

  task automatic model_step(input int s, input bit last);
    exp_t e;
    if (m_first) begin
      m_sum = 0;
      m_n   = 0;
    end
    m_sum   = m_sum + longint'(s) * longint'(s);
    m_n     = m_n + 1;
    m_first = last;
    if (last) begin
      e.ovf  = (m_sum > 64'sh0000_0000_FFFF_FFFF);
`ifdef SOS_SATURATE_EN
      e.data = e.ovf ? 32'hFFFF_FFFF : m_sum[31:0];
`else
      e.data = m_sum[31:0];
`endif
      e.len  = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
      e.len2 = (m_n > 3) ? 2'd3 : 2'(m_n);
      sb.push_back(e);
    end
  endtask

  task automatic send(input int s, input bit last);
    @(negedge clock);
    sample_in    = 16'(s);
    sample_valid = 1'b1;
    sample_last  = last;
    model_step(s, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      sample_valid = 1'b0;
      sample_last  = 1'b0;
    end
  endtask

  // Scoreboard: every output pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (data_valid || data_valid2) begin
      n_checks++;
      if (data_valid !== data_valid2) begin
        n_fail++;
        $display("FAIL pulse_align: data_valid=%b data_valid(cnt2)=%b, required equal", data_valid, data_valid2);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: data_out=%0h with no result expected", data_out);
      end else begin
        e = sb.pop_front();
        if (data_out !== e.data || overflow !== e.ovf || vec_len !== e.len) begin
          n_fail++;
          $display("FAIL result: data_out=%h ovf=%b vec_len=%0d, required %h %b %0d",
                   data_out, overflow, vec_len, e.data, e.ovf, e.len);
        end
        n_checks++;
        if (data_out2 !== e.data || overflow2 !== e.ovf || vec_len2 !== e.len2) begin
          n_fail++;
          $display("FAIL result_cnt2: data_out=%h ovf=%b vec_len=%0d, required %h %b %0d",
                   data_out2, overflow2, vec_len2, e.data, e.ovf, e.len2);
        end
      end
    end
  end

  task automatic test_reset;
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    repeat (2) @(negedge clock);
    sample_in    = 16'sd7;
    sample_valid = 1'b1;
    sample_last  = 1'b1;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (data_out !== 32'd0 || data_valid !== 1'b0 || overflow !== 1'b0 || vec_len !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: data_out=%h dv=%b ovf=%b len=%0d, required all zero",
                 data_out, data_valid, overflow, vec_len);
      end
    end
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    m_first      = 1'b1;
    send(-3, 1'b1);
    idle(1);
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_e0: data_valid=%b, required 0", data_valid);
    end
    @(negedge clock);
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_e1: data_valid=%b, required 0", data_valid);
    end
    @(negedge clock);
    n_checks++;
    if (data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_e2: data_valid=%b, required 1", data_valid);
    end
    @(negedge clock);
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width: data_valid=%b, required 0", data_valid);
    end
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_bubble;
    send(3, 1'b0);
    idle(1);
    send(4, 1'b1);
    idle(6);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL bubble_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) send(-32768, i == 3);
    send(1, 1'b1);
    idle(6);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int cur;
    int best;
    int total;
    cur   = 0;
    best  = 0;
    total = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (data_valid === 1'b1) begin
        cur++;
        total++;
        if (cur > best) best = cur;
      end else begin
        cur = 0;
      end
      if (i < 4) begin
        sample_in    = 16'(i + 1);
        sample_valid = 1'b1;
        sample_last  = 1'b1;
        model_step(i + 1, 1'b1);
      end else begin
        sample_valid = 1'b0;
        sample_last  = 1'b0;
      end
    end
    n_checks++;
    if (best !== 4 || total !== 4) begin
      n_fail++;
      $display("FAIL stream_pulses: run=%0d total=%0d, required 4 4", best, total);
    end
    // Two-element vector immediately followed by a one-element vector.
    send(6, 1'b0);
    send(7, 1'b1);
    send(-2, 1'b1);
    idle(6);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    send(5, 1'b0);
    send(5, 1'b0);
    @(negedge clock);
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    m_first      = 1'b1;
    @(negedge clock);
    reset        = 1'b0;
    idle(4);
    n_checks++;
    if (data_valid !== 1'b0 || data_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: dv=%b data_out=%h, required 0 0", data_valid, data_out);
    end
    send(2, 1'b1);
    idle(6);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_cnt_sat;
    for (int i = 0; i < 5; i++) send(1, i == 4);
    idle(6);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL cnt_sat_drain: %0d results outstanding, required 0", sb.size());
    end
    n_checks++;
    if (vec_len2 !== 2'd3 || vec_len !== 16'd5) begin
      n_fail++;
      $display("FAIL cnt_sat_hold: vec_len=%0d vec_len(cnt2)=%0d, required 5 3", vec_len, vec_len2);
    end
  endtask

  initial begin
    test_reset();
    test_bubble();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_cnt_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sum_of_squares.md
# sum_of_squares

Streaming energy accumulator that sits directly upstream of the square-root pipeline. It squares a stream of signed samples, sums the squares over a vector delimited by a last flag, and presents one 32-bit unsigned sum per vector on a valid/data pair. That pair feeds the root stage's data input and valid input directly. Results are produced at full throughput with a fixed three-cycle latency and no backpressure.

## Interface
- SAMPLE_W, default 16: signed sample width; legal range 2..16, so one square fits in 32 bits.
- CNT_W, default 16: width of the element counter and `vec_len`.

- clock, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high; clears all state on the edge where it is sampled high.
- sample_in, input, SAMPLE_W: signed two's-complement sample.
- sample_valid, input, 1: `sample_in` and `sample_last` are valid this cycle.
- sample_last, input, 1: this sample closes the current vector; ignored when `sample_valid`=0.
- data_out, output, 32: unsigned sum of squares of the last completed vector.
- data_valid, output, 1: one-cycle pulse marking a new `data_out`.
- overflow, output, 1: the sum for the current `data_out` exceeded 2^32−1; qualified by `data_valid`.
- vec_len, output, CNT_W: number of elements in the current `data_out` vector; saturates at 2^CNT_W−1.

## Operation
- Stage 1 (input register): captures sample, valid and last.
- Stage 2 (square): sq = sample × sample, signed multiply, stored as 32-bit unsigned. The maximum value (−2^(SAMPLE_W−1))² = 2^(2·SAMPLE_W−2) always fits.
- Stage 3 (accumulate): a `first` flag is set after reset and after every accepted last element.
- On a valid element:
  - acc_next = (first ? 0 : acc) + sq, computed at 33 bits.
  - ovf_next = (first ? 0 : ovf) | acc_next[32].
  - cnt_next = (first ? 1 : cnt + 1), saturating.
- Output register: loaded when the stage-3 element carries last.
  - `data_out`, `overflow`, `vec_len` are loaded from the next-state values.
  - `data_valid` pulses for one cycle.
- Invalid cycles (bubbles) flow through the pipeline and leave acc, cnt, ovf and `first` unchanged.
- A vector of one element is legal: `sample_valid`=1 with `sample_last`=1 on the first element.
- Back-to-back vectors need no idle cycle. The element after a last starts from zero in the same cycle that the previous result is registered.
- Outputs hold their value between pulses; the consumer samples only on `data_valid`.
- No backpressure: the downstream root stage accepts one item per cycle, so no ready input exists.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `overflow`=0, `vec_len`=0. Internal acc=0, cnt=0, ovf=0, `first`=1; all pipeline valid bits are 0.
- Latency: `data_valid` is high in the cycle that follows the third rising edge after the edge sampling the last element (edges E0, E1, E2; visible after E2).
- Throughput: one element per cycle. With `sample_valid` held high and `sample_last`=1 every cycle, `data_valid` is high every cycle after the pipeline fills.
- Reset mid-vector: the partial sum and any in-flight elements are discarded, and no `data_valid` is produced for them. The first valid sample after reset deasserts starts a new vector.
- Reset coincident with `sample_valid`: the sample is dropped.
- Counter saturation: `vec_len` sticks at 2^CNT_W−1; the accumulation continues correctly.
- Overflow is sticky within a vector and cleared when the next vector starts.

## Configuration
- `SOS_SATURATE_EN` defined:
  - Once ovf_next=1, the accumulator clamps to 32'hFFFF_FFFF and stays there for the rest of the vector.
  - `data_out` = 32'hFFFF_FFFF whenever `overflow`=1.
- `SOS_SATURATE_EN` undefined:
  - The accumulator wraps modulo 2^32, so `data_out` = true sum mod 2^32.
  - `overflow` is still reported.
- All other behaviour and the latency are identical in both builds.

## Test plan
- Reset, then a single element −3 with last at edge E0 → `data_valid`=1 after E2 only; `data_out`=9, `vec_len`=1, `overflow`=0; all outputs read 0 during reset.
- Vector (3, 4) with a one-cycle bubble between the elements → one pulse, `data_out`=25, `vec_len`=2.
- Vector of four elements of −32768 (SAMPLE_W=16) → sum 2^32, `overflow`=1, `vec_len`=4.
  - With `SOS_SATURATE_EN`: `data_out`=32'hFFFF_FFFF.
  - Without: `data_out`=0.
  - The following vector (1) gives `data_out`=1, `overflow`=0.
- Continuous stream with last every cycle, samples 1, 2, 3, 4 → four consecutive `data_valid` pulses with `data_out` 1, 4, 9, 16.
- Vector (5, 5, 5) with reset asserted for one cycle after the second element, then vector (2) → no pulse for the interrupted vector; next pulse has `data_out`=4, `vec_len`=1.
- CNT_W=2, vector of five elements of 1 → `data_out`=5, `vec_len`=3 (saturated), `overflow`=0.
